// File: rtl/stencil_pkg.sv
// Shared definitions for the 3x3 stencil filter user slot:
// register map, FSM states, default kernel and shift.
package stencil_pkg;

    localparam logic [19:0] REG_CTRL   = 20'h00000;
    localparam logic [19:0] REG_STATUS = 20'h00004;
    localparam logic [19:0] REG_COEF0  = 20'h00008;
    localparam logic [19:0] REG_SHIFT  = 20'h0002C;

    localparam int NTAP = 9;

    // Smoothing kernel 1,2,1 / 2,4,2 / 1,2,1 with a divide by 16
    localparam int DEF_COEF [NTAP] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    localparam logic [4:0] DEF_SHIFT = 5'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [19:0] coef_addr(input int k);
        return REG_COEF0 + 20'(4 * k);
    endfunction

endpackage

// File: rtl/stencil_line_buf.sv
// One image line store: simple dual-port RAM with a
// registered read port that holds its output when re is low.
module stencil_line_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stencil_filter_core.sv
// 3x3 programmable stencil filter over three buffered lines.
// Optional macro STENCIL_IRQ_EN enables the done interrupt.
module stencil_filter_core
    import stencil_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int PIX_W      = 8,
    parameter int LINE_WORDS = 64,
    parameter int COEF_W     = 8
) (
    input  logic              i_user_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_user_data,
    input  logic [19:0]       i_user_addr,
    input  logic              i_user_wr_req,
    input  logic              i_user_rd_req,
    output logic [31:0]       o_user_data,
    output logic              o_user_rd_ack,
    input  logic              i_pcie_str1_data_valid,
    input  logic [DATA_W-1:0] i_pcie_str1_data,
    output logic              o_pcie_str1_ack,
    input  logic              i_pcie_str2_data_valid,
    input  logic [DATA_W-1:0] i_pcie_str2_data,
    output logic              o_pcie_str2_ack,
    input  logic              i_pcie_str3_data_valid,
    input  logic [DATA_W-1:0] i_pcie_str3_data,
    output logic              o_pcie_str3_ack,
    output logic              o_pcie_str1_data_valid,
    output logic [DATA_W-1:0] o_pcie_str1_data,
    input  logic              i_pcie_str1_ack,
    output logic              o_intr_req,
    input  logic              i_intr_ack
);

    localparam int NPIX  = DATA_W / PIX_W;
    localparam int AW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int CW    = $clog2(LINE_WORDS + 1);
    localparam int ACC_W = PIX_W + COEF_W + 4;

    state_t                   state;
    logic [CW-1:0]            cnt [3];
    logic [CW-1:0]            len;
    logic [AW-1:0]            rd_ptr;
    logic                     done_q;
    logic                     err_q;
    logic signed [COEF_W-1:0] coef [NTAP];
    logic [4:0]               shift_q;

    logic                     s_vld [3];
    logic [DATA_W-1:0]        s_dat [3];
    logic                     s_ack [3];
    logic [DATA_W-1:0]        rd_data [3];

    logic                     s1_v, s1_first, s1_last;
    logic                     c_v, c_first, c_last;
    logic [DATA_W-1:0]        cur [3];
    logic [PIX_W-1:0]         prv [3];
    logic                     w_v, w_last;
    logic [PIX_W-1:0]         win    [3][NPIX+2];
    logic [PIX_W-1:0]         win_nx [3][NPIX+2];
    logic                     o_last;
    logic [DATA_W-1:0]        mac;
    logic [31:0]              rd_mux;

    logic busy, start_req, cfg_wr, lens_ok;
    logic adv, issue, last_rd, last_ack, enter_done;

    assign s_vld[0] = i_pcie_str1_data_valid;
    assign s_vld[1] = i_pcie_str2_data_valid;
    assign s_vld[2] = i_pcie_str3_data_valid;
    assign s_dat[0] = i_pcie_str1_data;
    assign s_dat[1] = i_pcie_str2_data;
    assign s_dat[2] = i_pcie_str3_data;
    assign o_pcie_str1_ack = s_ack[0];
    assign o_pcie_str2_ack = s_ack[1];
    assign o_pcie_str3_ack = s_ack[2];

    assign busy      = (state != ST_IDLE);
    assign start_req = i_user_wr_req && (i_user_addr == REG_CTRL)
                       && i_user_data[0];
    assign cfg_wr    = i_user_wr_req && !busy;
    assign lens_ok   = (cnt[0] == cnt[1]) && (cnt[1] == cnt[2])
                       && (cnt[1] != '0);

    assign adv        = !(o_pcie_str1_data_valid && !i_pcie_str1_ack);
    assign issue      = (state == ST_RUN) && adv;
    assign last_rd    = (CW'(rd_ptr) == len - CW'(1));
    assign last_ack   = o_pcie_str1_data_valid && o_last && i_pcie_str1_ack;
    assign enter_done = (state == ST_DRAIN) && last_ack;

    for (genvar n = 0; n < 3; n++) begin : g_line
        assign s_ack[n] = i_rst && s_vld[n] && !busy
                          && (cnt[n] < CW'(LINE_WORDS));

        stencil_line_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (LINE_WORDS),
            .AW     (AW)
        ) u_buf (
            .clk   (i_user_clk),
            .we    (s_ack[n]),
            .waddr (cnt[n][AW-1:0]),
            .wdata (s_dat[n]),
            .re    (issue),
            .raddr (rd_ptr),
            .rdata (rd_data[n])
        );
    end

    // Control FSM: line fill counts, start check, read pointer, status
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= ST_IDLE;
            len    <= '0;
            rd_ptr <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int n = 0; n < 3; n++) cnt[n] <= '0;
        end else begin
            for (int n = 0; n < 3; n++)
                if (s_ack[n]) cnt[n] <= cnt[n] + CW'(1);
            unique case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        done_q <= 1'b0;
                        if (lens_ok) begin
                            state  <= ST_RUN;
                            err_q  <= 1'b0;
                            len    <= cnt[1];
                            rd_ptr <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        if (last_rd) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (enter_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    for (int n = 0; n < 3; n++) cnt[n] <= '0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Kernel and shift registers, frozen while a run is active
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < NTAP; k++) coef[k] <= COEF_W'(DEF_COEF[k]);
            shift_q <= DEF_SHIFT;
        end else if (cfg_wr) begin
            for (int k = 0; k < NTAP; k++)
                if (i_user_addr == coef_addr(k))
                    coef[k] <= i_user_data[COEF_W-1:0];
            if (i_user_addr == REG_SHIFT) shift_q <= i_user_data[4:0];
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        if (i_user_addr == REG_STATUS) rd_mux = {29'b0, err_q, done_q, busy};
        if (i_user_addr == REG_SHIFT) rd_mux = {27'b0, shift_q};
        for (int k = 0; k < NTAP; k++)
            if (i_user_addr == coef_addr(k))
                rd_mux = {{(32-COEF_W){1'b0}}, coef[k]};
    end

    // Read data returns one cycle after the strobe
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_user_rd_ack <= 1'b0;
            o_user_data   <= '0;
        end else begin
            o_user_rd_ack <= i_user_rd_req;
            o_user_data   <= i_user_rd_req ? rd_mux : '0;
        end
    end

    // Window with clamped borders: left from previous word, right from next
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nx[r][0] = c_first ? cur[r][0 +: PIX_W] : prv[r];
            for (int i = 0; i < NPIX; i++)
                win_nx[r][i+1] = cur[r][i*PIX_W +: PIX_W];
            win_nx[r][NPIX+1] = c_last ? cur[r][DATA_W-1 -: PIX_W]
                                       : rd_data[r][0 +: PIX_W];
        end
    end

    // Per-pixel signed MAC, arithmetic shift, saturate to pixel range
    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] sh;
        logic [PIX_W-1:0]        res;
        acc = '0;
        sh  = '0;
        res = '0;
        mac = '0;
        for (int p = 0; p < NPIX; p++) begin
            acc = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    acc = acc
                        + $signed({{(ACC_W-PIX_W){1'b0}}, win[r][p+c]})
                        * $signed({{(ACC_W-COEF_W){coef[3*r+c][COEF_W-1]}},
                                   coef[3*r+c]});
            sh = acc >>> shift_q;
            if (sh[ACC_W-1])
                res = '0;
            else if (|sh[ACC_W-2:PIX_W])
                res = '1;
            else
                res = sh[PIX_W-1:0];
            mac[p*PIX_W +: PIX_W] = res;
        end
    end

    // Datapath pipeline; every stage holds while the output is stalled
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_v <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
            c_v  <= 1'b0; c_first  <= 1'b0; c_last  <= 1'b0;
            w_v  <= 1'b0; w_last   <= 1'b0;
            o_last <= 1'b0;
            o_pcie_str1_data_valid <= 1'b0;
            o_pcie_str1_data       <= '0;
            for (int r = 0; r < 3; r++) begin
                cur[r] <= '0;
                prv[r] <= '0;
                for (int i = 0; i < NPIX + 2; i++) win[r][i] <= '0;
            end
        end else if (adv) begin
            s1_v     <= issue;
            s1_first <= (rd_ptr == '0);
            s1_last  <= last_rd;
            c_v      <= s1_v;
            c_first  <= s1_first;
            c_last   <= s1_last;
            for (int r = 0; r < 3; r++) begin
                cur[r] <= rd_data[r];
                prv[r] <= cur[r][DATA_W-1 -: PIX_W];
            end
            w_v    <= c_v;
            w_last <= c_last;
            win    <= win_nx;
            o_pcie_str1_data_valid <= w_v;
            o_last                 <= w_last;
            o_pcie_str1_data       <= mac;
        end
    end

`ifdef STENCIL_IRQ_EN
    // Interrupt rises on entry to DONE and holds until acknowledged
    always_ff @(posedge i_user_clk or negedge i_rst) begin
        if (!i_rst)
            o_intr_req <= 1'b0;
        else if (enter_done)
            o_intr_req <= 1'b1;
        else if (i_intr_ack)
            o_intr_req <= 1'b0;
    end
`else
    assign o_intr_req = 1'b0;
    logic unused_intr;
    assign unused_intr = i_intr_ack;
`endif

    logic unused_data;
    assign unused_data = &{1'b0, i_user_data[31:COEF_W]};

endmodule

// File: tb/tb_stencil_filter_core.sv
// Scoreboard bench for stencil_filter_core: random lines,
// kernels and backpressure against a line-level reference.
module tb_stencil_filter_core;

    localparam int DATA_W = 64;
    localparam int NPIX   = 8;
    localparam int LW     = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       user_wdata = '0;
    logic [19:0]       user_addr = '0;
    logic              wr_req = 1'b0;
    logic              rd_req = 1'b0;
    logic [31:0]       user_rdata;
    logic              rd_ack;
    logic              s1_v = 1'b0, s2_v = 1'b0, s3_v = 1'b0;
    logic [DATA_W-1:0] s1_d = '0, s2_d = '0, s3_d = '0;
    logic              s1_a, s2_a, s3_a;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_ack = 1'b0;
    logic              intr_req;
    logic              intr_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int ack_mode = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] line_w [3][LW];
    int coef_m [9];
    int shift_m;

    always #5 clk = ~clk;

    stencil_filter_core dut (
        .i_user_clk             (clk),
        .i_rst                  (rst),
        .i_user_data            (user_wdata),
        .i_user_addr            (user_addr),
        .i_user_wr_req          (wr_req),
        .i_user_rd_req          (rd_req),
        .o_user_data            (user_rdata),
        .o_user_rd_ack          (rd_ack),
        .i_pcie_str1_data_valid (s1_v),
        .i_pcie_str1_data       (s1_d),
        .o_pcie_str1_ack        (s1_a),
        .i_pcie_str2_data_valid (s2_v),
        .i_pcie_str2_data       (s2_d),
        .o_pcie_str2_ack        (s2_a),
        .i_pcie_str3_data_valid (s3_v),
        .i_pcie_str3_data       (s3_d),
        .o_pcie_str3_ack        (s3_a),
        .o_pcie_str1_data_valid (o_valid),
        .o_pcie_str1_data       (o_data),
        .i_pcie_str1_ack        (o_ack),
        .o_intr_req             (intr_req),
        .i_intr_ack             (intr_ack)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int get_pix(input int r, input int x);
        logic [63:0] w;
        w = line_w[r][x / NPIX];
        return int'((w >> (8 * (x % NPIX))) & 64'hFF);
    endfunction

    // Reference: whole-line 3x3 convolution with clamped pixel index
    task automatic push_expected(input int len);
        int np, xx, acc;
        logic [63:0] word;
        np = len * NPIX;
        for (int w = 0; w < len; w++) begin
            word = '0;
            for (int i = 0; i < NPIX; i++) begin
                acc = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        xx = w * NPIX + i + c - 1;
                        if (xx < 0) xx = 0;
                        if (xx > np - 1) xx = np - 1;
                        acc += get_pix(r, xx) * coef_m[r*3+c];
                    end
                acc = acc >>> shift_m;
                if (acc < 0) acc = 0;
                if (acc > 255) acc = 255;
                word[8*i +: 8] = acc[7:0];
            end
            exp_q.push_back(word);
        end
    endtask

    // Monitor: drives sink ack, checks stability and pops the scoreboard
    initial begin
        logic held;
        logic phase;
        logic a;
        logic [63:0] held_d;
        held = 1'b0;
        phase = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("valid_held", o_valid, 1'b1);
                    check("data_stable", o_data, held_d);
                end
                case (ack_mode)
                    1:       a = phase;
                    2:       a = 1'($urandom % 2);
                    default: a = 1'b1;
                endcase
                o_ack = a;
                if (o_valid) begin
                    phase = ~phase;
                    if (a) begin
                        held = 1'b0;
                        out_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out: got %h expected none",
                                     o_data);
                        end else begin
                            check("out_data", o_data, exp_q.pop_front());
                        end
                    end else begin
                        held = 1'b1;
                        held_d = o_data;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic reg_write(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_req = 1'b1;
        user_addr = a;
        user_wdata = d;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic reg_read(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_req = 1'b1;
        user_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        check("rd_ack", rd_ack, 1'b1);
        d = user_rdata;
    endtask

    task automatic expect_reg(input string name, input logic [19:0] a,
                              input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(name, d, exp);
    endtask

    task automatic drive_str(input int n, input logic v, input logic [63:0] d);
        case (n)
            0: begin s1_v = v; s1_d = d; end
            1: begin s2_v = v; s2_d = d; end
            default: begin s3_v = v; s3_d = d; end
        endcase
    endtask

    function automatic logic str_ack(input int n);
        case (n)
            0: return s1_a;
            1: return s2_a;
            default: return s3_a;
        endcase
    endfunction

    task automatic load_lines(input int l0, input int l1, input int l2);
        int lens [3];
        int idx [3];
        lens = '{l0, l1, l2};
        idx = '{0, 0, 0};
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (idx[0] >= lens[0] && idx[1] >= lens[1] && idx[2] >= lens[2])
                break;
            for (int n = 0; n < 3; n++)
                drive_str(n, idx[n] < lens[n], line_w[n][idx[n] % LW]);
            #1;
            for (int n = 0; n < 3; n++)
                if (idx[n] < lens[n] && str_ack(n)) idx[n]++;
        end
        for (int n = 0; n < 3; n++) drive_str(n, 1'b0, '0);
        for (int n = 0; n < 3; n++)
            check($sformatf("load_len%0d", n), idx[n], lens[n]);
    endtask

    task automatic program_regs();
        for (int k = 0; k < 9; k++)
            reg_write(20'h8 + 20'(4 * k), 32'(coef_m[k] & 255));
        reg_write(20'h2C, 32'(shift_m));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
        expect_reg({name, "_status"}, 20'h4, 32'h2);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 3; r++)
            for (int w = 0; w < LW; w++)
                line_w[r][w] = {$urandom, $urandom};
    endtask

    task automatic run_full(input string name, input int len);
        load_lines(len, len, len);
        push_expected(len);
        reg_write(20'h0, 32'h1);
        wait_drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int acks, target, pos, len;
        logic [31:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_rd_ack", rd_ack, 1'b0);
        check("rst_rdata", user_rdata, 32'h0);
        check("rst_intr", intr_req, 1'b0);
        rst = 1'b1;
        expect_reg("rst_status", 20'h4, 32'h0);
        coef_m = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        shift_m = 4;
        for (int k = 0; k < 9; k++)
            expect_reg($sformatf("rst_coef%0d", k), 20'h8 + 20'(4 * k),
                       32'(coef_m[k]));
        expect_reg("rst_shift", 20'h2C, 32'd4);

        // Flat 0x40 image through default kernel, with latency check
        for (int r = 0; r < 3; r++)
            for (int w = 0; w < LW; w++) line_w[r][w] = 64'h4040404040404040;
        ack_mode = 0;
        load_lines(LW, LW, LW);
        push_expected(LW);
        reg_write(20'h0, 32'h1);
        repeat (3) @(negedge clk);
        check("latency_pre", o_valid, 1'b0);
        @(negedge clk);
        check("latency_first", o_valid, 1'b1);
        check("flat_word0", o_data, 64'h4040404040404040);
        wait_drain("flat");
`ifdef STENCIL_IRQ_EN
        check("intr_set", intr_req, 1'b1);
        repeat (5) @(negedge clk);
        check("intr_hold", intr_req, 1'b1);
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        check("intr_clear", intr_req, 1'b0);
`else
        check("intr_off", intr_req, 1'b0);
`endif

        // Identity kernel with 1010 sink ack and a write while busy
        coef_m = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        shift_m = 0;
        program_regs();
        fill_random();
        ack_mode = 1;
        load_lines(LW, LW, LW);
        push_expected(LW);
        reg_write(20'h0, 32'h1);
        reg_write(20'h2C, 32'd7);
        reg_write(20'h18, 32'h55);
        wait_drain("ident");
        expect_reg("busy_shift", 20'h2C, 32'd0);
        expect_reg("busy_coef4", 20'h18, 32'd1);

        // Start with empty buffers after done
        reg_write(20'h0, 32'h1);
        expect_reg("empty_err", 20'h4, 32'h4);

        // Short stream 3: error, then stream 3 saturates at LINE_WORDS
        fill_random();
        load_lines(LW, LW, 10);
        reg_write(20'h0, 32'h1);
        expect_reg("short_err", 20'h4, 32'h4);
        repeat (10) @(negedge clk);
        check("short_novalid", o_valid, 1'b0);
        acks = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            drive_str(2, 1'b1, line_w[2][(10 + acks) % LW]);
            #1;
            if (s3_a) acks++;
        end
        drive_str(2, 1'b0, '0);
        check("str3_full_acks", acks, LW - 10);
        ack_mode = 2;
        push_expected(LW);
        reg_write(20'h0, 32'h1);
        wait_drain("refill");

        // Laplacian-like kernel on single bright pixels, incl. borders
        coef_m = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        shift_m = 0;
        program_regs();
        for (int t = 0; t < 3; t++) begin
            len = (t == 2) ? 5 : LW;
            pos = (t == 0) ? int'($urandom_range(0, LW * NPIX - 1))
                : (t == 1) ? 0 : len * NPIX - 1;
            for (int r = 0; r < 3; r++)
                for (int w = 0; w < LW; w++) line_w[r][w] = '0;
            line_w[1][pos / NPIX][8 * (pos % NPIX) +: 8] = 8'hFF;
            run_full($sformatf("lap%0d", t), len);
        end

        // Random kernels, shifts, lengths and backpressure
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 9; k++)
                coef_m[k] = int'($urandom_range(0, 255)) - 128;
            shift_m = int'($urandom_range(0, 10));
            program_regs();
            fill_random();
            len = (t == 0) ? 1 : int'($urandom_range(1, LW));
            run_full($sformatf("rand%0d", t), len);
        end

        // Reset after 20 output words
        coef_m = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        shift_m = 4;
        program_regs();
        fill_random();
        ack_mode = 0;
        load_lines(LW, LW, LW);
        push_expected(LW);
        target = out_cnt + 20;
        reg_write(20'h0, 32'h1);
        for (int i = 0; i < 500 && out_cnt < target; i++) @(negedge clk);
        check("midrst_reached", out_cnt >= target, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_intr", intr_req, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_reg("midrst_status", 20'h4, 32'h0);
        repeat (10) @(negedge clk);
        check("midrst_idle", o_valid, 1'b0);
        reg_write(20'h0, 32'h1);
        expect_reg("midrst_cleared", 20'h4, 32'h4);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
